// File: rtl/lf_arith_pkg.sv
// Shared types and prefix-cell equations for the Ladner-Fischer arithmetic blocks.
package lf_arith_pkg;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Combines a high span with the adjacent lower span into one group term.
    function automatic pg_t black_op(input pg_t hi, input pg_t lo);
        return '{p: hi.p & lo.p, g: hi.g | (hi.p & lo.g)};
    endfunction

    function automatic logic gray_op(input pg_t hi, input logic g_lo);
        return hi.g | (hi.p & g_lo);
    endfunction

endpackage

// File: rtl/lf_sub16_pipe_if.sv
// Operand/result handshake bundle for the pipelined LF subtractor.
interface lf_sub16_pipe_if;
    import lf_arith_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   D;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, X, Y, out_ready,
        input  in_ready, out_valid, D, zero, ovf
    );

    modport slave (
        input  in_valid, X, Y, out_ready,
        output in_ready, out_valid, D, zero, ovf
    );

endinterface

// File: rtl/lf_prefix16.sv
// Combinational 16-bit Ladner-Fischer prefix tree, split after the level that
// forms 4-bit spans so the caller can register the group terms there.
module lf_prefix16
    import lf_arith_pkg::*;
(
    input  pg_t [WIDTH-1:0]  pg,
    input  logic             cin,
    output pg_t [WIDTH-1:0]  grp_l2,
    input  pg_t [WIDTH-1:0]  grp_l2_q,
    output logic [WIDTH-1:0] carry
);

    pg_t [WIDTH-1:0] lvl1, lvl3, lvl4;

    for (genvar i = 0; i < WIDTH; i++) begin : g_l1
        if ((i / 1) % 2 == 1) begin : g_cell
            assign lvl1[i] = black_op(pg[i], pg[(i / 1) * 1 - 1]);
        end else begin : g_pass
            assign lvl1[i] = pg[i];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_l2
        if ((i / 2) % 2 == 1) begin : g_cell
            assign grp_l2[i] = black_op(lvl1[i], lvl1[(i / 2) * 2 - 1]);
        end else begin : g_pass
            assign grp_l2[i] = lvl1[i];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_l3
        if ((i / 4) % 2 == 1) begin : g_cell
            assign lvl3[i] = black_op(grp_l2_q[i], grp_l2_q[(i / 4) * 4 - 1]);
        end else begin : g_pass
            assign lvl3[i] = grp_l2_q[i];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_l4
        if ((i / 8) % 2 == 1) begin : g_cell
            assign lvl4[i] = black_op(lvl3[i], lvl3[(i / 8) * 8 - 1]);
        end else begin : g_pass
            assign lvl4[i] = lvl3[i];
        end
        // Every node now spans [i:0]; fold in the carry-in to get carry out of bit i.
        assign carry[i] = gray_op(lvl4[i], cin);
    end

endmodule

// File: rtl/lf_sub16_pipe.sv
// Pipelined 16-bit LF subtractor: D = X + ~Y + 1 with borrow, zero and signed
// overflow flags, behind a valid/ready handshake of depth STAGES (1 or 2).
module lf_sub16_pipe
    import lf_arith_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    lf_sub16_pipe_if.slave bus
);

    localparam logic CIN = 1'b1;

    logic [WIDTH-1:0] y_inv, p_bits, g_bits;
    pg_t  [WIDTH-1:0] pg, grp_l2, mid_grp;
    logic [WIDTH-1:0] mid_p, carry, sum;
    logic             mid_valid, mid_x15, mid_y15;
    logic             out_advance;

    assign y_inv  = ~bus.Y;
    assign p_bits = bus.X ^ y_inv;
    assign g_bits = bus.X & y_inv;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pg
        assign pg[i] = '{p: p_bits[i], g: g_bits[i]};
    end

    lf_prefix16 u_prefix (
        .pg       (pg),
        .cin      (CIN),
        .grp_l2   (grp_l2),
        .grp_l2_q (mid_grp),
        .carry    (carry)
    );

    assign out_advance = bus.out_ready || !bus.out_valid;

    if (STAGES == 2) begin : g_two
        logic             s1_valid;
        pg_t  [WIDTH-1:0] s1_grp;
        logic [WIDTH-1:0] s1_p;
        logic             s1_x15, s1_y15;

        assign bus.in_ready = !s1_valid || out_advance;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid <= 1'b0;
                s1_grp   <= '0;
                s1_p     <= '0;
                s1_x15   <= 1'b0;
                s1_y15   <= 1'b0;
            end else begin
                if (bus.in_ready) s1_valid <= bus.in_valid;
                // NOTE: payload loads only on an accepted transfer; the valid bit alone tracks occupancy.
                if (bus.in_ready && bus.in_valid) begin
                    s1_grp <= grp_l2;
                    s1_p   <= p_bits;
                    s1_x15 <= bus.X[WIDTH-1];
                    s1_y15 <= bus.Y[WIDTH-1];
                end
            end
        end

        assign mid_valid = s1_valid;
        assign mid_grp   = s1_grp;
        assign mid_p     = s1_p;
        assign mid_x15   = s1_x15;
        assign mid_y15   = s1_y15;
    end else if (STAGES == 1) begin : g_one
        assign bus.in_ready = out_advance;
        assign mid_valid    = bus.in_valid;
        assign mid_grp      = grp_l2;
        assign mid_p        = p_bits;
        assign mid_x15      = bus.X[WIDTH-1];
        assign mid_y15      = bus.Y[WIDTH-1];
    end else begin : g_bad
        $error("lf_sub16_pipe: STAGES must be 1 or 2");
    end

    assign sum = mid_p ^ {carry[WIDTH-2:0], CIN};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.D         <= '0;
            bus.zero      <= 1'b0;
            bus.ovf       <= 1'b0;
        end else if (out_advance) begin
            bus.out_valid <= mid_valid;
            if (mid_valid) begin
                bus.D    <= {~carry[WIDTH-1], sum};
                bus.zero <= (sum == '0);
                bus.ovf  <= (mid_x15 != mid_y15) && (sum[WIDTH-1] != mid_x15);
            end
        end
    end

endmodule
